// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encodings, reset vector and next-pc op codes.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  localparam logic [1:0] ST_REQ    = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_SQUASH = 2'd2;

  typedef enum logic [1:0] {
    NPC_PC4    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_JR     = 2'd3
  } npc_op_e;

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_seq_pc_reg.sv
// Program-counter register: 32-bit, load enable, resets to the fetch reset vector.
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= RESET_PC;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: issues one fetch at a time, holds the word for decode,
// and squashes in-flight fetches when the resolved next-pc redirects the stream.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        pc_load;
  logic [31:0] pend_pc;
  logic        pend_load;
  logic        capture;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .load (pc_load),
    .d    (pc_d),
    .q    (pc_q)
  );

  // A redirect arriving together with the squashed fetch's ack is the newest target.
  always_comb begin
    state_nxt = state;
    pc_load   = 1'b0;
    pc_d      = pc_q;
    pend_load = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_REQ: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            pc_load = 1'b1;
            pc_d    = redirect_pc;
          end else begin
            capture   = 1'b1;
            state_nxt = ST_HOLD;
          end
        end else if (redirect_valid) begin
          pend_load = 1'b1;
          state_nxt = ST_SQUASH;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_load   = 1'b1;
          pc_d      = redirect_pc;
          state_nxt = ST_REQ;
        end else if (out_ready) begin
          pc_load   = 1'b1;
          pc_d      = seq_pc(out_pc);
          state_nxt = ST_REQ;
        end
      end
      ST_SQUASH: begin
        if (imem_ack) begin
          pc_load   = 1'b1;
          pc_d      = redirect_valid ? redirect_pc : pend_pc;
          state_nxt = ST_REQ;
        end else if (redirect_valid) begin
          pend_load = 1'b1;
        end
      end
      default: state_nxt = ST_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_REQ;
      pend_pc   <= 32'd0;
      out_pc    <= 32'd0;
      out_instr <= 32'd0;
    end else begin
      state <= state_nxt;
      if (pend_load)
        pend_pc <= redirect_pc;
      if (capture) begin
        out_pc    <= pc_q;
        out_instr <= imem_rdata;
      end
    end
  end

  // Request is withheld during reset so an abandoned fetch is never re-presented.
  assign imem_req  = !rst && (state != ST_HOLD);
  assign imem_addr = pc_q;
  assign out_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: cycle vector table plus hand-written redirect/reset sequences.
module tb_fetch_seq;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic        ack;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_opc;
    logic        push;
  } vec_t;

  vec_t tbl [14];

  fetch_seq #(.RESET_PC(32'h0000_3000)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_ready      (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, ~a[15:0]};
  endfunction

  assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check pre-edge outputs, score any transfer, advance.
  task automatic applyStimulus(input string name, input logic ack, input logic rdy, input logic rv,
                               input logic [31:0] rpc, input logic e_req, input logic [31:0] e_addr,
                               input logic e_valid, input logic [31:0] e_opc, input logic push);
    logic [31:0] exp_pc;
    imem_ack       = ack;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    checkOutput({name, " imem_req"}, {31'd0, imem_req}, {31'd0, e_req});
    if (e_req) checkOutput({name, " imem_addr"}, imem_addr, e_addr);
    checkOutput({name, " out_valid"}, {31'd0, out_valid}, {31'd0, e_valid});
    if (e_valid) begin
      checkOutput({name, " out_pc"}, out_pc, e_opc);
      checkOutput({name, " out_instr"}, out_instr, mem_word(e_opc));
    end
    if (push) sb_q.push_back(e_addr);
    if (out_valid && rdy && !rv) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("[TB] FAIL %s transfer: got unexpected pc %h, expected none", name, out_pc);
      end else begin
        exp_pc = sb_q.pop_front();
        checkOutput({name, " sb_pc"}, out_pc, exp_pc);
        checkOutput({name, " sb_instr"}, out_instr, mem_word(exp_pc));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           ack   rdy   rv    rpc           req   addr          valid opc           push
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_3000, 1'b0, 32'h0,        1'b1};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_3000, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_3004, 1'b0, 32'h0,        1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_3004, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_3004, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_3004, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_3004, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_3004, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_3004, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_3008, 1'b0, 32'h0,        1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 32'h0000_3100, 1'b0, 32'h0,        1'b1, 32'h0000_3008, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_3100, 1'b0, 32'h0,        1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_3100, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_3104, 1'b0, 32'h0,        1'b1};

    rst            = 1'b1;
    imem_ack       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset imem_req", {31'd0, imem_req}, 32'd0);
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset out_pc", out_pc, 32'd0);
    checkOutput("reset out_instr", out_instr, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++)
      applyStimulus($sformatf("vec%0d", i), tbl[i].ack, tbl[i].rdy, tbl[i].rv, tbl[i].rpc,
                    tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid, tbl[i].e_opc, tbl[i].push);

    // Delayed ack with two redirects while waiting: last one wins, data discarded.
    applyStimulus("sq_hold",  1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_3104, 1'b0);
    applyStimulus("sq_w1",    1'b0, 1'b1, 1'b1, 32'h0000_3200, 1'b1, 32'h0000_3108, 1'b0, 32'h0,         1'b0);
    applyStimulus("sq_w2",    1'b0, 1'b1, 1'b1, 32'h0000_3300, 1'b1, 32'h0000_3108, 1'b0, 32'h0,         1'b0);
    applyStimulus("sq_ack",   1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_3108, 1'b0, 32'h0,         1'b0);
    applyStimulus("sq_next",  1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_3300, 1'b0, 32'h0,         1'b1);
    applyStimulus("sq_out",   1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_3300, 1'b0);

    // Redirect coinciding with ack in REQ, then address wrap at the top of memory.
    applyStimulus("rq_redir", 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_3304, 1'b0, 32'h0,         1'b0);
    applyStimulus("wr_fetch", 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         1'b1);
    applyStimulus("wr_out",   1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0);
    applyStimulus("wr_zero",  1'b1, 1'b1, 1'b1, 32'h0000_3001, 1'b1, 32'h0000_0000, 1'b0, 32'h0,         1'b0);
    applyStimulus("unalign",  1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_3001, 1'b0, 32'h0,         1'b0);

    // Reset while a fetch is outstanding; the stale ack must not produce output.
    rst      = 1'b1;
    imem_ack = 1'b1;
    #1;
    checkOutput("rst_mid imem_req", {31'd0, imem_req}, 32'd0);
    checkOutput("rst_mid out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus("rel_0",    1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_3000, 1'b0, 32'h0,         1'b0);
    applyStimulus("rel_1",    1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_3000, 1'b0, 32'h0,         1'b1);
    applyStimulus("rel_out",  1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_3000, 1'b0);
    applyStimulus("rel_next", 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_3004, 1'b0, 32'h0,         1'b0);

    checkOutput("scoreboard empty", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
